module_nibble_add_ctrl: RTL and testbench
=========================================

MODULE_NIBBLE_ADD_CTRL -- requirements
Module: module_nibble_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 2..8; operand width W = 4*NIBBLES.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand pair offered.
REQ-005 Port: in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 Port: A  input  W  first operand, sampled on accept.
REQ-007 Port: B  input  W  second operand, sampled on accept.
REQ-008 Port: sub  input  1  operation select, sampled on accept; present only when NIBBLE_SUB_EN is defined.
REQ-009 Port: out_valid  output  1  Res is valid.
REQ-010 Port: out_ready  input  1  consumer takes Res.
REQ-011 Port: Res  output  W+1  result; bit W is the final carry-out.
REQ-012 Port: busy  output  1  high while in RUN.

Function
REQ-013 The block SHALL add A and B using one shared 4-bit adder slice with carry-in, iterating over nibbles LSB first.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 Accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready is 1, and 0 otherwise.
REQ-017 On accept, the block SHALL latch A, B (and sub), clear the nibble index and carry register (set carry to 1 for subtract), clear Res, and enter RUN.
REQ-018 In RUN, each cycle SHALL compute the sum of nibble[idx] of A, B and the carry register, write the 4-bit sum into Res nibble idx, update the carry, and increment idx.
REQ-019 When RUN processes idx == NIBBLES-1, the block SHALL write the carry into Res[W] and enter DONE.
REQ-020 out_valid SHALL be 1 only in DONE; latency SHALL be exactly NIBBLES cycles from the accept edge to out_valid high.
REQ-021 In DONE, Res and out_valid SHALL hold stable until out_ready is 1.
REQ-022 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-023 DONE with out_ready=1 and in_valid=1 SHALL accept the new pair and enter RUN on the same edge, with no idle cycle.
REQ-024 in_valid in RUN SHALL be ignored; A and B changes in RUN SHALL NOT affect the result.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 Arithmetic SHALL be unsigned modulo 2^(W+1), with no saturation.

Reset
REQ-027 Asserting rst SHALL immediately force state to IDLE, with in_ready=1 after release, out_valid=0, busy=0, Res=0, and carry and idx=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow release.

Configuration
REQ-029 Macro NIBBLE_SUB_EN: when defined, the sub port SHALL exist; sub=1 SHALL compute A + ~B + 1, so Res[W-1:0] = A-B mod 2^W and Res[W] = 1 means no borrow.
REQ-030 Without NIBBLE_SUB_EN, the sub port SHALL be absent and only addition SHALL be performed, with carry-in 0.

Verification (NIBBLES=4)
REQ-031 Accept A=0xFFFF, B=0x0001 -> out_valid exactly 4 cycles later, Res=0x10000.
REQ-032 Accept A=0x1234, B=0x4321, hold out_ready=0 for 5 cycles -> Res=0x05555 held stable, in_ready=0 throughout, then one handshake, then IDLE.
REQ-033 Back-to-back: in DONE, out_ready=1 and in_valid=1 with A=0x00FF, B=0x0001 -> same-edge accept, next Res=0x00100 after 4 cycles, busy never drops between.
REQ-034 Assert rst during RUN at idx=2 -> all outputs 0 immediately, no out_valid after release, next accept of 0x0001+0x0001 gives 0x00002.
REQ-035 Change A and B every cycle during RUN -> result equals sum of values latched at accept.
REQ-036 With NIBBLE_SUB_EN, sub=1, A=0x0003, B=0x0005 -> Res=0x0FFFE (bit16=0, borrow); A=0x0005, B=0x0003 -> Res=0x10002.

Source files
------------

// File: rtl/module_nibble_add_ctrl_if.sv
// Handshake bundle for module_nibble_add_ctrl: operand offer, result return and busy flag.
// The sub select exists only when NIBBLE_SUB_EN is defined.
interface module_nibble_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef NIBBLE_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   Res;
    logic         busy;

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Res,
        output busy
`ifdef NIBBLE_SUB_EN
        , input sub
`endif
    );

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Res,
        input  busy
`ifdef NIBBLE_SUB_EN
        , output sub
`endif
    );
endinterface

// File: rtl/module_nibble_add_ctrl.sv
// Serial nibble adder: one 4-bit slice with carry, LSB nibble first, NIBBLES cycles per result.
// Define NIBBLE_SUB_EN to add the sub select (A + ~B + 1).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one nibble per cycle through the shared slice, busy=1
// DONE  | Res valid, held until out_ready; may accept the next pair on the same edge
module module_nibble_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    module_nibble_add_ctrl_if.slave  bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [IDX_W-1:0] r_idx;
    logic           r_carry;
    logic [W:0]     r_res;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_busy;
    logic           w_accept;
    logic           w_last;
    logic           w_sub_in;
    logic [3:0]     w_nib_a;
    logic [3:0]     w_nib_b;
    logic [4:0]     w_slice;
    logic [W:0]     w_res_next;

`ifdef NIBBLE_SUB_EN
    assign w_sub_in = bus.sub;
`else
    assign w_sub_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) w_state_next = bus.in_valid ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib_a = r_a[i*4 +: 4];
                w_nib_b = r_b[i*4 +: 4];
            end
        end
    end

    assign w_slice = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, r_carry};

    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) w_res_next[i*4 +: 4] = w_slice[3:0];
        end
        if (w_last) w_res_next[W] = w_slice[4];
    end

    // Subtract is folded in at accept: B is stored inverted and the carry starts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= w_sub_in ? ~bus.B : bus.B;
            r_idx   <= '0;
            r_carry <= w_sub_in;
            r_res   <= '0;
        end else if (r_state == RUN) begin
            r_res   <= w_res_next;
            r_carry <= w_slice[4];
            r_idx   <= r_idx + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.Res       = r_res;
endmodule

// File: tb/tb_module_nibble_add_ctrl.sv
// Bench for module_nibble_add_ctrl: directed cases plus randomized traffic against a cycle-level model.
module tb_module_nibble_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_sub = 1'b0;

    module_nibble_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();
    module_nibble_add_ctrl #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef NIBBLE_SUB_EN
    assign bus.sub = s_sub;
`endif

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: remaining run cycles, a result-pending flag and the expected result.
    int         m_cnt  = 0;
    bit         m_done = 1'b0;
    logic [W:0] m_res  = '0;

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    function automatic bit cur_sub();
`ifdef NIBBLE_SUB_EN
        return s_sub;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        return (m_cnt == 0 && !m_done) || (m_done && bus.out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc;
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            acc = bus.in_valid && exp_ready();
            if (m_done && bus.out_ready) m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end
            if (acc) begin
                m_cnt = NIBBLES;
                m_res = ref_op(bus.A, bus.B, cur_sub());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_done));
            check("busy", 64'(bus.busy), 64'(m_cnt > 0));
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
            if (m_done) check("Res", 64'(bus.Res), 64'(m_res));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        s_sub        = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles until out_valid (bounded) and how often busy was low before it.
    task automatic wait_valid(output int cyc, output int drops);
        cyc   = 0;
        drops = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (bus.out_valid) break;
            if (!bus.busy) drops++;
        end
    endtask

    task automatic handshake_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int c;
        int d;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_Res", 64'(bus.Res), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // carry ripples through every nibble
        offer(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(c, d);
        check("latency_ffff", 64'(c), 64'd4);
        check("res_ffff", 64'(bus.Res), 64'h10000);
        handshake_out();
        check("idle_after_ffff", 64'(bus.in_ready), 64'd1);

        // result held under backpressure
        offer(16'h1234, 16'h4321, 1'b0);
        wait_valid(c, d);
        check("latency_1234", 64'(c), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check("hold_res", 64'(bus.Res), 64'h05555);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        handshake_out();
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // back-to-back accept from DONE
        offer(16'h0010, 16'h0020, 1'b0);
        wait_valid(c, d);
        check("res_0030", 64'(bus.Res), 64'h00030);
        bus.out_ready = 1'b1;
        offer(16'h00FF, 16'h0001, 1'b0);
        bus.out_ready = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_out_valid", 64'(bus.out_valid), 64'd0);
        wait_valid(c, d);
        check("b2b_latency", 64'(c), 64'd4);
        check("b2b_busy_drops", 64'(d), 64'd0);
        check("b2b_res", 64'(bus.Res), 64'h00100);
        handshake_out();

        // reset in the middle of RUN
        offer(16'h1111, 16'h2222, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_Res", 64'(bus.Res), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        d = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) d++;
        end
        check("midrst_no_valid", 64'(d), 64'd0);
        bus.out_ready = 1'b0;
        offer(16'h0001, 16'h0001, 1'b0);
        wait_valid(c, d);
        check("after_rst_res", 64'(bus.Res), 64'h00002);
        handshake_out();

        // operands change during RUN
        offer(16'h0A0A, 16'h0505, 1'b0);
        c = 0;
        while (!bus.out_valid && c < 20) begin
            bus.A        = W'($urandom);
            bus.B        = W'($urandom);
            bus.in_valid = 1'b1;
            tick();
            c++;
        end
        bus.in_valid = 1'b0;
        check("noisy_latency", 64'(c), 64'd4);
        check("noisy_res", 64'(bus.Res), 64'h00F0F);
        handshake_out();

`ifdef NIBBLE_SUB_EN
        offer(16'h0003, 16'h0005, 1'b1);
        wait_valid(c, d);
        check("sub_borrow", 64'(bus.Res), 64'h0FFFE);
        handshake_out();
        offer(16'h0005, 16'h0003, 1'b1);
        wait_valid(c, d);
        check("sub_noborrow", 64'(bus.Res), 64'h10002);
        handshake_out();
`endif

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.out_ready = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 3))
                0:       bus.A = '1;
                1:       bus.A = '0;
                default: bus.A = W'($urandom);
            endcase
            bus.B = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
`ifdef NIBBLE_SUB_EN
            s_sub = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
